sprite_motion: RTL and testbench
================================

SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 Parameter SCR_W, default 640, visible screen width in pixels.
REQ-002 Parameter SCR_H, default 480, visible screen height in pixels.
REQ-003 Parameter IMG_W, default 160, and IMG_H, default 120, sprite size in pixels.
REQ-004 Parameter STEP, default 3, horizontal pixels per tick; JUMP_V, default 12, initial rise speed; GRAVITY, default 1; MAX_V, default 12, fall speed cap.
REQ-005 Parameter DEAD_LO, default 400, and DEAD_HI, default 600, joystick X dead-zone bounds; X0, default 0, reset X.
REQ-006 clk  in  1  system clock; single clock domain, all state on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 tick  in  1  one-clk update strobe (5 Hz joystick poll rate).
REQ-009 jstk_x  in  10  joystick X; jump_btn  in  1  jump button level.
REQ-010 h_cnt, v_cnt  in  10 each  VGA scan counters.
REQ-011 img_x, img_y  out  10 each  sprite top-left position.
REQ-012 in_area  out  1  current scan pixel lies inside the sprite; tex_addr  out  17  sprite ROM address.
REQ-013 airborne  out  1  motion state is not GROUND; landed  out  1  one-clk pulse on landing.

Function
REQ-014 Position, velocity and state SHALL update only on clk edges where tick=1; the new values SHALL be visible on the following cycle.
REQ-015 Horizontal motion: jstk_x<DEAD_LO moves left by STEP and jstk_x>DEAD_HI moves right by STEP, with X clamped to [0, SCR_W-IMG_W]; otherwise X holds.
REQ-016 FLOOR is SCR_H-IMG_H; the motion state machine SHALL have the states GROUND, RISE and FALL, with a 5-bit velocity register vel.
REQ-017 Jump edge: on each tick, jump_btn SHALL be sampled into btn_prev; a jump is jump_btn=1 with btn_prev=0, and a button held across a landing SHALL NOT re-jump.
REQ-018 GROUND: a jump SHALL set vel to JUMP_V and the state to RISE; Y holds.
REQ-019 RISE: if vel=0, the state SHALL become FALL with Y unchanged.
REQ-020 RISE: else if Y<vel, Y SHALL become 0, vel SHALL become 0 and the state SHALL become FALL.
REQ-021 RISE: otherwise Y -= vel and vel -= GRAVITY, saturating at 0.
REQ-022 FALL: vel_n = min(vel+GRAVITY, MAX_V); if Y+vel_n>=FLOOR then Y=FLOOR, vel=0, state=GROUND and landed pulses for one clk; else Y += vel_n and vel = vel_n.
REQ-023 Jumps SHALL be ignored while airborne; horizontal motion SHALL continue in all states.
REQ-024 in_area SHALL be registered, with 1-clk latency after h_cnt/v_cnt: img_x<=h_cnt<img_x+IMG_W and img_y<=v_cnt<img_y+IMG_H.
REQ-025 tex_addr SHALL be registered, with 1-clk latency: (v_cnt-img_y)*IMG_W+(h_cnt-img_x) when in area, else 0; the arithmetic SHALL be 17-bit and never wrap inside the area.
REQ-026 airborne SHALL be combinational from the state register.

Reset
REQ-027 rst=1 SHALL force img_x=X0, img_y=FLOOR, vel=0, state=GROUND, btn_prev=0, in_area=0, tex_addr=0 and landed=0 immediately, independent of clk.
REQ-028 rst asserted mid-jump SHALL abort the jump; after release, the first tick SHALL behave as from GROUND.
REQ-029 rst SHALL take priority over a simultaneous tick.

Configuration
REQ-030 With SPRITE_MOTION_WRAP_EN defined, a left step at X=0 SHALL go to SCR_W-IMG_W and a right step at X=SCR_W-IMG_W SHALL go to 0; steps from other X SHALL clamp as in REQ-015.
REQ-031 Without SPRITE_MOTION_WRAP_EN, X SHALL saturate at both edges with no wrap.

Verification
REQ-032 Reset, then jump_btn=1 and 25 ticks -> Y=348 after tick 1 and 282 after tick 12, held at tick 13, 360 with a landed pulse at tick 25, airborne low from then.
REQ-033 jump_btn held for 40 ticks -> exactly one jump; airborne stays 0 after landing.
REQ-034 jstk_x=100 for 5 ticks from X=6 -> X goes 3, 0, 0, 0, 0; with SPRITE_MOTION_WRAP_EN -> 3, 0, 480, 477, 474.
REQ-035 jstk_x=900 from X=478 -> X=480 and saturates there (wrap build: next tick gives 0); jstk_x=500 -> X holds.
REQ-036 Sprite at (0,360), h_cnt=5, v_cnt=362 -> next clk in_area=1, tex_addr=325; h_cnt=160 -> in_area=0, tex_addr=0.
REQ-037 rst pulsed at rise tick 6 -> Y=360, vel=0, GROUND within the same cycle; the next jump repeats the REQ-032 sequence.

Source files
------------

// File: rtl/sprite_motion.sv
// Sprite position/jump controller for a VGA overlay: joystick steps X, a jump button drives a
// GROUND/RISE/FALL arc in Y, and the scan counters are mapped to sprite ROM addresses.
// Optional build macro SPRITE_MOTION_WRAP_EN makes X wrap around the screen edges instead of saturating.
module sprite_motion #(
  parameter int SCR_W   = 640,
  parameter int SCR_H   = 480,
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int STEP    = 3,
  parameter int JUMP_V  = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_V   = 12,
  parameter int DEAD_LO = 400,
  parameter int DEAD_HI = 600,
  parameter int X0      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [9:0]  jstk_x,
  input  logic        jump_btn,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [9:0]  img_x,
  output logic [9:0]  img_y,
  output logic        in_area,
  output logic [16:0] tex_addr,
  output logic        airborne,
  output logic        landed
);

  localparam logic [9:0]  X_MAX  = 10'(SCR_W - IMG_W);
  localparam logic [9:0]  FLOOR  = 10'(SCR_H - IMG_H);
  localparam logic [9:0]  STEP_X = 10'(STEP);
  localparam logic [9:0]  DZ_LO  = 10'(DEAD_LO);
  localparam logic [9:0]  DZ_HI  = 10'(DEAD_HI);
  localparam logic [4:0]  V_JUMP = 5'(JUMP_V);
  localparam logic [4:0]  V_GRAV = 5'(GRAVITY);
  localparam logic [4:0]  V_MAX  = 5'(MAX_V);
  localparam logic [10:0] SPR_W  = 11'(IMG_W);
  localparam logic [10:0] SPR_H  = 11'(IMG_H);
  localparam logic [16:0] ROW_W  = 17'(IMG_W);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [4:0]  vel_q, vel_d, vel_up;
  logic        btn_prev_q, btn_prev_d;
  logic        landed_q, landed_d;
  logic        in_area_q, in_area_d;
  logic [16:0] tex_q, tex_d;
  logic [9:0]  dx, dy;

  function automatic logic [9:0] step_left(input logic [9:0] x);
    logic [9:0] r;
    r = (x < STEP_X) ? 10'd0 : x - STEP_X;
`ifdef SPRITE_MOTION_WRAP_EN
    if (x == 10'd0) r = X_MAX;
`endif
    return r;
  endfunction

  function automatic logic [9:0] step_right(input logic [9:0] x);
    logic [9:0] r;
    r = (({1'b0, x} + {1'b0, STEP_X}) > {1'b0, X_MAX}) ? X_MAX : x + STEP_X;
`ifdef SPRITE_MOTION_WRAP_EN
    if (x == X_MAX) r = 10'd0;
`endif
    return r;
  endfunction

  // Falling speed grows by gravity but never beyond the terminal velocity.
  function automatic logic [4:0] fall_speed(input logic [4:0] v);
    logic [5:0] s;
    s = {1'b0, v} + {1'b0, V_GRAV};
    return (s > {1'b0, V_MAX}) ? V_MAX : s[4:0];
  endfunction

  function automatic logic [4:0] rise_speed(input logic [4:0] v);
    return (v < V_GRAV) ? 5'd0 : v - V_GRAV;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GROUND;
      x_q        <= 10'(X0);
      y_q        <= FLOOR;
      vel_q      <= 5'd0;
      btn_prev_q <= 1'b0;
      landed_q   <= 1'b0;
      in_area_q  <= 1'b0;
      tex_q      <= 17'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      btn_prev_q <= btn_prev_d;
      landed_q   <= landed_d;
      in_area_q  <= in_area_d;
      tex_q      <= tex_d;
    end
  end

  assign vel_up = fall_speed(vel_q);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    btn_prev_d = btn_prev_q;
    landed_d   = 1'b0;
    if (tick) begin
      btn_prev_d = jump_btn;
      if (jstk_x < DZ_LO)      x_d = step_left(x_q);
      else if (jstk_x > DZ_HI) x_d = step_right(x_q);
      case (state_q)
        GROUND: begin
          // Edge-detected so a button held through a landing cannot re-launch.
          if (jump_btn && !btn_prev_q) begin
            vel_d   = V_JUMP;
            state_d = RISE;
          end
        end
        RISE: begin
          if (vel_q == 5'd0) begin
            state_d = FALL;
          end else if (y_q < {5'd0, vel_q}) begin
            y_d     = 10'd0;
            vel_d   = 5'd0;
            state_d = FALL;
          end else begin
            y_d   = y_q - {5'd0, vel_q};
            vel_d = rise_speed(vel_q);
          end
        end
        FALL: begin
          if (({1'b0, y_q} + {6'd0, vel_up}) >= {1'b0, FLOOR}) begin
            y_d      = FLOOR;
            vel_d    = 5'd0;
            state_d  = GROUND;
            landed_d = 1'b1;
          end else begin
            y_d   = y_q + {5'd0, vel_up};
            vel_d = vel_up;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  // Scan lookup uses the position held before this edge; the offsets are non-negative inside the area.
  always_comb begin
    in_area_d = ({1'b0, h_cnt} >= {1'b0, x_q}) && ({1'b0, h_cnt} < ({1'b0, x_q} + SPR_W)) &&
                ({1'b0, v_cnt} >= {1'b0, y_q}) && ({1'b0, v_cnt} < ({1'b0, y_q} + SPR_H));
    dx    = h_cnt - x_q;
    dy    = v_cnt - y_q;
    tex_d = in_area_d ? (({7'd0, dy} * ROW_W) + {7'd0, dx}) : 17'd0;
  end

  always_comb begin
    airborne = (state_q != GROUND);
    landed   = landed_q;
  end

  assign img_x    = x_q;
  assign img_y    = y_q;
  assign in_area  = in_area_q;
  assign tex_addr = tex_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Scoreboard bench for sprite_motion: stimulus pushes expected outputs from a behavioural model,
// a monitor pops and compares one entry per clock; directed trajectory checks are added on top.
module tb_sprite_motion;

  localparam int FLOOR = 360;
  localparam int XMAX  = 480;
  localparam int SPR_W = 160;
  localparam int SPR_H = 120;
  localparam int PH_GROUND = 0;
  localparam int PH_UP     = 1;
  localparam int PH_DOWN   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [9:0]  jstk_x = 10'd500;
  logic        jump_btn = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic [9:0]  img_x, img_y;
  logic        in_area;
  logic [16:0] tex_addr;
  logic        airborne, landed;

  sprite_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .jstk_x(jstk_x), .jump_btn(jump_btn),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .img_x(img_x), .img_y(img_y),
    .in_area(in_area), .tex_addr(tex_addr), .airborne(airborne), .landed(landed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int ia;
    int ta;
    int ab;
    int ld;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position, speed, phase of the jump arc, previous button level.
  int mx, my, mv, mph;
  bit mprev;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int move_x(input int x, input int jx);
    int n;
    n = x;
    if (jx < 400) begin
`ifdef SPRITE_MOTION_WRAP_EN
      if (x == 0) return XMAX;
`endif
      n = x - 3;
      if (n < 0) n = 0;
    end else if (jx > 600) begin
`ifdef SPRITE_MOTION_WRAP_EN
      if (x == XMAX) return 0;
`endif
      n = x + 3;
      if (n > XMAX) n = XMAX;
    end
    return n;
  endfunction

  task automatic apply(input bit r, input bit t, input int jx, input bit jb, input int h, input int v);
    exp_t e;
    bit   jump;
    int   vn;
    @(negedge clk);
    rst = r; tick = t; jstk_x = 10'(jx); jump_btn = jb; h_cnt = 10'(h); v_cnt = 10'(v);
    e.ld = 0;
    if (r) begin
      mx = 0; my = FLOOR; mv = 0; mph = PH_GROUND; mprev = 0;
      e.ia = 0; e.ta = 0;
      #1;
      check("rst_now_x", img_x, 0);
      check("rst_now_y", img_y, FLOOR);
      check("rst_now_airborne", airborne, 0);
      check("rst_now_landed", landed, 0);
      check("rst_now_in_area", in_area, 0);
      check("rst_now_tex", tex_addr, 0);
    end else begin
      e.ia = (h >= mx && h < mx + SPR_W && v >= my && v < my + SPR_H) ? 1 : 0;
      e.ta = e.ia ? (v - my) * SPR_W + (h - mx) : 0;
      if (t) begin
        jump  = jb && !mprev;
        mprev = jb;
        mx = move_x(mx, jx);
        if (mph == PH_GROUND) begin
          if (jump) begin mv = 12; mph = PH_UP; end
        end else if (mph == PH_UP) begin
          if (mv == 0) mph = PH_DOWN;
          else if (my < mv) begin my = 0; mv = 0; mph = PH_DOWN; end
          else begin my = my - mv; mv = (mv > 1) ? mv - 1 : 0; end
        end else begin
          vn = (mv + 1 > 12) ? 12 : mv + 1;
          if (my + vn >= FLOOR) begin my = FLOOR; mv = 0; mph = PH_GROUND; e.ld = 1; end
          else begin my = my + vn; mv = vn; end
        end
      end
    end
    e.x = mx; e.y = my; e.ab = (mph != PH_GROUND) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock presents a fresh output set, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("img_x", img_x, e.x);
        check("img_y", img_y, e.y);
        check("in_area", in_area, e.ia);
        check("tex_addr", tex_addr, e.ta);
        check("airborne", airborne, e.ab);
        check("landed", landed, e.ld);
      end
    end
  end

  initial begin
    int exp34[5];
    int xr, h, v;
    bit jb;
`ifdef SPRITE_MOTION_WRAP_EN
    exp34 = '{3, 0, 480, 477, 474};
`else
    exp34 = '{3, 0, 0, 0, 0};
`endif

    // Jump arc from reset with the button held.
    apply(1, 0, 500, 0, 0, 0);
    apply(0, 0, 500, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      apply(0, 1, 500, 1, 0, 0);
      after_edge();
      if (k == 1)  check("arc_t1_y", img_y, 348);
      if (k == 12) check("arc_t12_y", img_y, 282);
      if (k == 13) check("arc_t13_y", img_y, 282);
      if (k == 24) check("arc_t24_landed", landed, 0);
      if (k == 25) begin
        check("arc_t25_y", img_y, 360);
        check("arc_t25_landed", landed, 1);
      end
      if (k >= 25) check("held_btn_airborne", airborne, 0);
    end

    // Left edge from X=6.
    apply(1, 0, 500, 0, 0, 0);
    apply(0, 1, 900, 0, 0, 0);
    apply(0, 1, 900, 0, 0, 0);
    after_edge();
    check("x_start6", img_x, 6);
    for (int k = 0; k < 5; k++) begin
      apply(0, 1, 100, 0, 0, 0);
      after_edge();
      check("x_left_edge", img_x, exp34[k]);
    end

    // Right edge: walk to 480, step back, then push against the edge.
    apply(1, 0, 500, 0, 0, 0);
    for (int k = 0; k < 160; k++) apply(0, 1, 900, 0, 0, 0);
    after_edge();
    check("x_at_max", img_x, 480);
    apply(0, 1, 100, 0, 0, 0);
    apply(0, 1, 900, 0, 0, 0);
    after_edge();
    check("x_477_to_480", img_x, 480);
    apply(0, 1, 900, 0, 0, 0);
    after_edge();
`ifdef SPRITE_MOTION_WRAP_EN
    xr = 0;
`else
    xr = 480;
`endif
    check("x_right_edge", img_x, xr);
    apply(0, 1, 500, 0, 0, 0);
    after_edge();
    check("x_deadzone_hold", img_x, xr);

    // Scan mapping at (0,360).
    apply(1, 0, 500, 0, 0, 0);
    apply(0, 0, 500, 0, 5, 362);
    after_edge();
    check("scan_in_area", in_area, 1);
    check("scan_tex", tex_addr, 325);
    apply(0, 0, 500, 0, 159, 362);
    after_edge();
    check("scan_last_col_tex", tex_addr, 479);
    apply(0, 0, 500, 0, 160, 362);
    after_edge();
    check("scan_out_area", in_area, 0);
    check("scan_out_tex", tex_addr, 0);

    // Reset aborts a jump mid-rise; the next jump repeats the arc.
    apply(1, 0, 500, 0, 0, 0);
    apply(0, 0, 500, 0, 0, 0);
    for (int k = 0; k < 7; k++) apply(0, 1, 500, 1, 0, 0);
    after_edge();
    check("midjump_airborne", airborne, 1);
    apply(1, 1, 500, 1, 0, 0);
    apply(0, 0, 500, 1, 0, 0);
    for (int k = 0; k < 13; k++) begin
      apply(0, 1, 500, 1, 0, 0);
      after_edge();
      if (k == 1)  check("rearc_t1_y", img_y, 348);
      if (k == 12) check("rearc_t12_y", img_y, 282);
    end

    // Randomized traffic with occasional resets.
    apply(1, 0, 500, 0, 0, 0);
    jb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) jb = ~jb;
      h = mx + $urandom_range(0, 180) - 10;
      v = my + $urandom_range(0, 140) - 10;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 1023) h = 1023;
      if (v > 1023) v = 1023;
      apply(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1023), jb, h, v);
    end

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
